// File: rtl/hc_sub_64_pipe.sv
// Two-stage pipelined 64-bit subtractor (a - b - bin) with a prefix carry tree cut after
// the 8-bit group level, elastic valid/ready handshake and compare flags.
module hc_sub_64_pipe #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned CUT_LEVEL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    // Prefix levels [0, CUT_LEVEL): group generate/propagate over spans up to 2^CUT_LEVEL bits.
    function automatic logic [2*WIDTH-1:0] prefix_gp(input logic [WIDTH-1:0] g,
                                                     input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] gc, pc, gn, pn;
        gc = g;
        pc = p;
        for (int unsigned k = 0; k < CUT_LEVEL; k++) begin
            gn = gc;
            pn = pc;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i >= (32'd1 << k)) begin
                    gn[i] = gc[i] | (pc[i] & gc[i - (32'd1 << k)]);
                    pn[i] = pc[i] & pc[i - (32'd1 << k)];
                end
            end
            gc = gn;
            pc = pn;
        end
        return {pc, gc};
    endfunction

    // Remaining levels: only the 0-anchored generate (the carry out of each bit) is needed.
    function automatic logic [WIDTH-1:0] prefix_finish(input logic [WIDTH-1:0] g,
                                                       input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] gc, pc, gn, pn;
        gc = g;
        pc = p;
        for (int unsigned k = CUT_LEVEL; k < LEVELS; k++) begin
            gn = gc;
            pn = pc;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i >= (32'd1 << k)) begin
                    gn[i] = gc[i] | (pc[i] & gc[i - (32'd1 << k)]);
                    pn[i] = pc[i] & pc[i - (32'd1 << k)];
                end
            end
            gc = gn;
            pc = pn;
        end
        return gc;
    endfunction

    logic             s1_valid, s2_valid;
    logic             s1_advance, accept, s2_load;
    logic [WIDTH-1:0] s1_p, s1_g_grp, s1_p_grp;
    logic             s1_cin, s1_a_msb, s1_b_msb;

    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !flush && (!s1_valid || s1_advance);
    assign accept     = in_valid && in_ready;
    assign s2_load    = s1_valid && s1_advance && !flush;
    assign out_valid  = s2_valid;

    // Stage 1 combinational: bit p/g of a + ~b with ~bin folded into bit 0's generate.
    logic [WIDTH-1:0]   p_bit, g_bit;
    logic               cin;
    logic [2*WIDTH-1:0] pg_grp;

    always_comb begin
        cin      = ~bin;
        p_bit    = a ^ ~b;
        g_bit    = a & ~b;
        g_bit[0] = g_bit[0] | (p_bit[0] & cin);
        pg_grp   = prefix_gp(g_bit, p_bit);
    end

    // Stage 2 combinational: complete the carries and form result and flags.
    logic [WIDTH-1:0] g_full, carry, diff_c;
    logic             bout_c, ovf_c;

    always_comb begin
        g_full = prefix_finish(s1_g_grp, s1_p_grp);
        carry  = {g_full[WIDTH-2:0], s1_cin};
        diff_c = s1_p ^ carry;
        bout_c = ~g_full[WIDTH-1];
        ovf_c  = (s1_a_msb != s1_b_msb) && (diff_c[WIDTH-1] != s1_a_msb);
    end

    // Valid bits: flush drops everything in flight, data registers untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept)
                s1_valid <= 1'b1;
            else if (s1_advance)
                s1_valid <= 1'b0;
            if (s1_advance)
                s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_p     <= '0;
            s1_g_grp <= '0;
            s1_p_grp <= '0;
            s1_cin   <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (accept) begin
            s1_p     <= p_bit;
            s1_g_grp <= pg_grp[WIDTH-1:0];
            s1_p_grp <= pg_grp[2*WIDTH-1:WIDTH];
            s1_cin   <= cin;
            s1_a_msb <= a[WIDTH-1];
            s1_b_msb <= b[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else if (s2_load) begin
            diff <= diff_c;
            bout <= bout_c;
            zero <= (diff_c == '0);
            neg  <= diff_c[WIDTH-1];
            ovf  <= ovf_c;
        end
    end

endmodule

// File: tb/tb_hc_sub_64_pipe.sv
// Scoreboard bench for hc_sub_64_pipe: directed corner cases, backpressure, flush, then
// random traffic with asynchronous reset pulses.
module tb_hc_sub_64_pipe;

    logic        clk, rst_n;
    logic        in_valid, in_ready, bin, flush;
    logic [63:0] a, b, diff;
    logic        out_valid, out_ready, bout, zero, neg, ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    logic [67:0] sb_q[$];

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    hc_sub_64_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {bout, zero, neg, ovf, diff} from plain 65-bit arithmetic.
    function automatic logic [67:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic mbin);
        logic [64:0] r;
        logic        v;
        r = {1'b0, ma} - {1'b0, mb} - 65'(mbin);
        v = (ma[63] != mb[63]) && (r[63] != ma[63]);
        return {r[64], r[63:0] == 64'd0, r[63], v, r[63:0]};
    endfunction

    task automatic drive(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                         input logic ibin, input logic ordy, input logic fl);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Sample at the falling edge: score output/input transfers of the coming rising edge.
    task automatic half();
        logic [67:0] exp;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0)
                check("sb_spurious", 68'(out_valid), 68'(0));
            else begin
                exp = sb_q.pop_front();
                check("sb_result", {bout, zero, neg, ovf, diff}, exp);
            end
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(model(a, b, bin));
            n_acc++;
        end
        if (flush)
            sb_q.delete();
    endtask

    task automatic rest();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] flags, input logic [63:0] d);
        check({tag, "_valid"}, 68'(out_valid), 68'(1));
        check(tag, {bout, zero, neg, ovf, diff}, {flags, d});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1, 0);
        #3;
        check("rst_valid", 68'(out_valid), 68'(0));
        check("rst_data", {bout, zero, neg, ovf, diff}, 68'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rest();

        // Basic subtraction and two-cycle latency
        drive(1, 64'd10, 64'd3, 0, 1, 0); half(); check("t1_in_ready", 68'(in_ready), 68'(1)); rest();
        drive(0, 0, 0, 0, 1, 0);          half(); check("t1_lat", 68'(out_valid), 68'(0)); rest();
        half(); expect_out("t1_out", 4'b0000, 64'd7); rest();

        // Wrap-around: 0 - 1 and 5 - 5 - 1
        drive(1, 64'd0, 64'd1, 0, 1, 0); half(); rest();
        drive(1, 64'd5, 64'd5, 1, 1, 0); half(); rest();
        drive(0, 0, 0, 0, 1, 0);
        half(); expect_out("t2_wrap0", 4'b1010, ONES); rest();
        half(); expect_out("t2_wrap1", 4'b1010, ONES); rest();

        // Signed overflow, then zero result
        drive(1, 64'h8000_0000_0000_0000, 64'd1, 0, 1, 0); half(); rest();
        drive(1, 64'h1234, 64'h1234, 0, 1, 0); half(); rest();
        drive(0, 0, 0, 0, 1, 0);
        half(); expect_out("t3_ovf", 4'b0001, 64'h7FFF_FFFF_FFFF_FFFF); rest();
        half(); expect_out("t3_zero", 4'b0100, 64'd0); rest();

        // Backpressure: two accepts fill the pipe, then drain in order
        for (int i = 1; i <= 2; i++) begin
            drive(1, 64'(i), 64'd1, 0, 0, 0); half(); check("bp_acc", 68'(in_ready), 68'(1)); rest();
        end
        drive(1, 64'd3, 64'd1, 0, 0, 0); half(); check("bp_full", 68'(in_ready), 68'(0)); rest();
        half(); check("bp_full2", 68'(in_ready), 68'(0)); expect_out("bp_hold", 4'b0100, 64'd0); rest();
        drive(1, 64'd3, 64'd1, 0, 1, 0); half(); expect_out("bp_d0", 4'b0100, 64'd0);
        check("bp_reopen", 68'(in_ready), 68'(1)); rest();
        drive(1, 64'd4, 64'd1, 0, 1, 0); half(); expect_out("bp_d1", 4'b0000, 64'd1); rest();
        drive(0, 0, 0, 0, 1, 0);
        half(); expect_out("bp_d2", 4'b0000, 64'd2); rest();
        half(); expect_out("bp_d3", 4'b0000, 64'd3); rest();
        half(); check("bp_empty", 68'(out_valid), 68'(0)); rest();

        // Flush with two ops in flight and a competing input
        drive(1, 64'd100, 64'd1, 0, 0, 0); half(); rest();
        drive(1, 64'd200, 64'd1, 0, 0, 0); half(); rest();
        drive(1, 64'd300, 64'd1, 0, 0, 1); half(); check("fl_in_ready", 68'(in_ready), 68'(0)); rest();
        drive(0, 0, 0, 0, 1, 0);
        half(); check("fl_out0", 68'(out_valid), 68'(0)); rest();
        half(); check("fl_out1", 68'(out_valid), 68'(0)); rest();
        drive(1, 64'd9, 64'd4, 0, 1, 0); half(); rest();
        drive(0, 0, 0, 0, 1, 0); half(); check("fl_lat", 68'(out_valid), 68'(0)); rest();
        half(); expect_out("fl_new", 4'b0000, 64'd5); rest();

        // Random traffic with occasional asynchronous reset pulses
        n_acc = 0;
        for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra = 64'd0;
                2: rb = ONES;
                default: ;
            endcase
            drive($urandom_range(0, 9) < 7, ra, rb, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 7, 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                check("rnd_rst_valid", 68'(out_valid), 68'(0));
                check("rnd_rst_data", {bout, zero, neg, ovf, diff}, 68'(0));
                #1 rst_n = 1'b1;
                sb_q.delete();
            end
            half();
            rest();
        end
        check("rnd_accepts", 68'(n_acc), 68'(10000));

        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            half();
            rest();
        end
        check("drain", 68'(sb_q.size()), 68'(0));
        half(); check("drain_idle", 68'(out_valid), 68'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
